// File: rtl/my_graphics_axi_regs.sv
// AXI4-Lite slave with four 32-bit read/write registers for the graphics core.
// Each register is exported in parallel, and a one-cycle pulse marks every write commit.
module my_graphics_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_out,
  output logic [3:0]                      reg_wr_pulse
);

  localparam int NumRegs  = 4;
  localparam int NumBytes = C_S_AXI_DATA_WIDTH / 8;

  logic                          resetDone_q;
  logic                          awFull_q;
  logic [1:0]                    awIdx_q;
  logic                          wFull_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wData_q;
  logic [NumBytes-1:0]           wStrb_q;
  logic                          bValid_q;
  logic [3:0]                    wrPulse_q;
  logic                          rValid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rData_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [NumRegs];
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [NumRegs];

  logic awHs, wHs, arHs, commit;
  logic unusedBits;

  // Readies stay low while in reset and come up on the first edge afterwards.
  assign s00_axi_awready = resetDone_q && !awFull_q && !bValid_q;
  assign s00_axi_wready  = resetDone_q && !wFull_q && !bValid_q;
  assign s00_axi_arready = resetDone_q && !rValid_q;

  assign awHs   = s00_axi_awvalid && s00_axi_awready;
  assign wHs    = s00_axi_wvalid && s00_axi_wready;
  assign arHs   = s00_axi_arvalid && s00_axi_arready;
  assign commit = awFull_q && wFull_q;

  assign s00_axi_bresp  = 2'b00;
  assign s00_axi_rresp  = 2'b00;
  assign s00_axi_bvalid = bValid_q;
  assign s00_axi_rvalid = rValid_q;
  assign s00_axi_rdata  = rData_q;
  assign reg_wr_pulse   = wrPulse_q;
  assign reg0_out       = regs_q[0];
  assign reg1_out       = regs_q[1];
  assign reg2_out       = regs_q[2];
  assign reg3_out       = regs_q[3];

  assign unusedBits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  always_comb begin
    for (int r = 0; r < NumRegs; r++) regs_d[r] = regs_q[r];
    if (commit) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (wStrb_q[b]) regs_d[awIdx_q][8*b +: 8] = wData_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      resetDone_q <= 1'b0;
      awFull_q    <= 1'b0;
      awIdx_q     <= '0;
      wFull_q     <= 1'b0;
      wData_q     <= '0;
      wStrb_q     <= '0;
      bValid_q    <= 1'b0;
      wrPulse_q   <= '0;
      rValid_q    <= 1'b0;
      rData_q     <= '0;
      for (int r = 0; r < NumRegs; r++) regs_q[r] <= '0;
    end else begin
      resetDone_q <= 1'b1;
      for (int r = 0; r < NumRegs; r++) regs_q[r] <= regs_d[r];

      if (awHs) begin
        awFull_q <= 1'b1;
        awIdx_q  <= s00_axi_awaddr[3:2];
      end else if (commit) begin
        awFull_q <= 1'b0;
      end

      if (wHs) begin
        wFull_q <= 1'b1;
        wData_q <= s00_axi_wdata;
        wStrb_q <= s00_axi_wstrb;
      end else if (commit) begin
        wFull_q <= 1'b0;
      end

      if (commit) bValid_q <= 1'b1;
      else if (s00_axi_bready) bValid_q <= 1'b0;

      wrPulse_q <= commit ? (4'b0001 << awIdx_q) : 4'b0000;

      // regs_q is sampled before this edge's commit lands, so a colliding read sees the old value.
      if (arHs) begin
        rValid_q <= 1'b1;
        rData_q  <= regs_q[s00_axi_araddr[3:2]];
      end else if (s00_axi_rready) begin
        rValid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_my_graphics_axi_regs.sv
// Self-checking bench for my_graphics_axi_regs: directed scenarios plus randomized
// write/read traffic compared against an array-based register model.
module tb_my_graphics_axi_regs;

  logic        clk = 1'b0;
  logic        rstN;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] reg0Out, reg1Out, reg2Out, reg3Out;
  logic [3:0]  regWrPulse;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [4];

  always #5 clk = ~clk;

  my_graphics_axi_regs dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rstN),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .reg0_out        (reg0Out),
    .reg1_out        (reg1Out),
    .reg2_out        (reg2Out),
    .reg3_out        (reg3Out),
    .reg_wr_pulse    (regWrPulse)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] mask = '0;
    for (int i = 0; i < 4; i++) if (strb[i]) mask = mask | (32'hFF << (8 * i));
    return (old & ~mask) | (data & mask);
  endfunction

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRegOuts(input string tag);
    checkOutput({tag, "_reg0"}, reg0Out, model[0]);
    checkOutput({tag, "_reg1"}, reg1Out, model[1]);
    checkOutput({tag, "_reg2"}, reg2Out, model[2]);
    checkOutput({tag, "_reg3"}, reg3Out, model[3]);
  endtask

  // Drives AW and W with independent start delays, then checks the commit one edge after the later handshake.
  task automatic writeReq(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awDelay, input int wDelay);
    bit awDone = 0, wDone = 0, awHs, wHs;
    int cyc = 0;
    while (!(awDone && wDone)) begin
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = !awDone && (cyc >= awDelay);
      wvalid  = !wDone && (cyc >= wDelay);
      awHs    = awvalid && awready;
      wHs     = wvalid && wready;
      waitEdge();
      cyc++;
      if (awHs) begin
        awDone = 1;
        checkOutput("awready_after_aw_hs", 32'(awready), 32'd0);
      end
      if (wHs) begin
        wDone = 1;
        checkOutput("wready_after_w_hs", 32'(wready), 32'd0);
      end
      if (cyc > 200) begin
        awvalid = 0;
        wvalid  = 0;
        checkOutput("write_hs_timeout", 32'(cyc), 32'd0);
        return;
      end
    end
    awvalid = 0;
    wvalid  = 0;
    checkOutput("bvalid_before_commit", 32'(bvalid), 32'd0);
    model[addr[3:2]] = mergeBytes(model[addr[3:2]], data, strb);
    waitEdge();
    checkOutput("bvalid_at_commit", 32'(bvalid), 32'd1);
    checkOutput("bresp", 32'(bresp), 32'd0);
    checkOutput("wr_pulse_at_commit", 32'(regWrPulse), 32'(4'b0001 << addr[3:2]));
    checkRegOuts("commit");
  endtask

  task automatic writeResp(input int bDelay);
    for (int i = 0; i < bDelay; i++) begin
      waitEdge();
      checkOutput("bvalid_held", 32'(bvalid), 32'd1);
      checkOutput("awready_while_bvalid", 32'(awready), 32'd0);
      checkOutput("wready_while_bvalid", 32'(wready), 32'd0);
      checkOutput("wr_pulse_one_cycle", 32'(regWrPulse), 32'd0);
    end
    bready = 1;
    waitEdge();
    bready = 0;
    checkOutput("bvalid_after_bready", 32'(bvalid), 32'd0);
    checkOutput("wr_pulse_after_resp", 32'(regWrPulse), 32'd0);
    checkOutput("awready_after_resp", 32'(awready), 32'd1);
    checkOutput("wready_after_resp", 32'(wready), 32'd1);
  endtask

  task automatic axiRead(input logic [3:0] addr, input int rDelay);
    bit hs = 0;
    int cyc = 0;
    logic [31:0] expected;
    arvalid = 1;
    araddr  = addr;
    while (!hs) begin
      hs = arready;
      expected = model[addr[3:2]];
      waitEdge();
      cyc++;
      if (cyc > 200) begin
        arvalid = 0;
        checkOutput("read_hs_timeout", 32'(cyc), 32'd0);
        return;
      end
    end
    arvalid = 0;
    checkOutput("rvalid_after_ar", 32'(rvalid), 32'd1);
    checkOutput("rdata", rdata, expected);
    checkOutput("rresp", 32'(rresp), 32'd0);
    checkOutput("arready_while_rvalid", 32'(arready), 32'd0);
    for (int i = 0; i < rDelay; i++) begin
      waitEdge();
      checkOutput("rvalid_held", 32'(rvalid), 32'd1);
      checkOutput("rdata_stable", rdata, expected);
      checkOutput("arready_held_low", 32'(arready), 32'd0);
    end
    rready = 1;
    waitEdge();
    rready = 0;
    checkOutput("rvalid_after_rready", 32'(rvalid), 32'd0);
    checkOutput("arready_after_rready", 32'(arready), 32'd1);
  endtask

  task automatic applyStimulus(input int count);
    for (int n = 0; n < count; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        writeReq(4'($urandom_range(15, 0)), $urandom, 4'($urandom_range(15, 0)),
                 $urandom_range(3, 0), $urandom_range(3, 0));
        writeResp($urandom_range(3, 0));
      end else begin
        axiRead(4'($urandom_range(15, 0)), $urandom_range(2, 0));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstN = 0;
    awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arprot = 0; arvalid = 0; rready = 0;
    for (int i = 0; i < 4; i++) model[i] = '0;

    #1;
    checkRegOuts("reset");
    checkOutput("reset_bvalid", 32'(bvalid), 32'd0);
    checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_pulse", 32'(regWrPulse), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1;
    waitEdge();
    checkOutput("post_reset_awready", 32'(awready), 32'd1);
    checkOutput("post_reset_wready", 32'(wready), 32'd1);
    checkOutput("post_reset_arready", 32'(arready), 32'd1);

    $display("[TB] sequential write/readback");
    for (int i = 0; i < 4; i++) begin
      writeReq(4'(4 * i), 32'(i + 1), 4'hF, 0, 0);
      writeResp(0);
    end
    for (int i = 0; i < 4; i++) axiRead(4'(4 * i), 0);

    $display("[TB] byte strobes");
    writeReq(4'h8, 32'h11223344, 4'hF, 0, 0);
    writeResp(0);
    writeReq(4'h8, 32'hAABBCCDD, 4'b0011, 0, 0);
    checkOutput("strobe_reg2_value", reg2Out, 32'h1122CCDD);
    checkOutput("strobe_pulse", 32'(regWrPulse), 32'h4);
    writeResp(1);
    axiRead(4'h8, 0);

    $display("[TB] zero strobe still commits");
    writeReq(4'h8, 32'hFFFFFFFF, 4'h0, 0, 0);
    checkOutput("zero_strobe_reg2", reg2Out, 32'h1122CCDD);
    writeResp(0);

    $display("[TB] decoupled channels");
    writeReq(4'h4, 32'hDEADBEEF, 4'hF, 3, 0);
    checkOutput("decoupled_reg1", reg1Out, 32'hDEADBEEF);
    writeResp(0);

    $display("[TB] write backpressure");
    writeReq(4'h0, 32'hCAFE0001, 4'hF, 0, 0);
    awvalid = 1; awaddr = 4'h0; wvalid = 1; wdata = 32'hCAFE0002; wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      waitEdge();
      checkOutput("bp_bvalid_held", 32'(bvalid), 32'd1);
      checkOutput("bp_awready_low", 32'(awready), 32'd0);
      checkOutput("bp_wready_low", 32'(wready), 32'd0);
      checkOutput("bp_reg0_unchanged", reg0Out, 32'hCAFE0001);
    end
    bready = 1;
    waitEdge();
    bready = 0;
    checkOutput("bp_bvalid_cleared", 32'(bvalid), 32'd0);
    writeReq(4'h0, 32'hCAFE0002, 4'hF, 0, 0);
    checkOutput("bp_second_commit", reg0Out, 32'hCAFE0002);
    writeResp(0);

    $display("[TB] read backpressure");
    axiRead(4'h4, 4);

    $display("[TB] same-edge collision");
    writeReq(4'hC, 32'h5, 4'hF, 0, 0);
    writeResp(0);
    awvalid = 1; awaddr = 4'hC; wvalid = 1; wdata = 32'h9; wstrb = 4'hF;
    checkOutput("coll_awready", 32'(awready), 32'd1);
    checkOutput("coll_wready", 32'(wready), 32'd1);
    waitEdge();
    awvalid = 0; wvalid = 0;
    arvalid = 1; araddr = 4'hC;
    checkOutput("coll_arready", 32'(arready), 32'd1);
    waitEdge();
    arvalid = 0;
    model[3] = 32'h9;
    checkOutput("coll_rvalid", 32'(rvalid), 32'd1);
    checkOutput("coll_rdata_old", rdata, 32'h5);
    checkOutput("coll_bvalid", 32'(bvalid), 32'd1);
    checkOutput("coll_reg3_new", reg3Out, 32'h9);
    rready = 1; bready = 1;
    waitEdge();
    rready = 0; bready = 0;
    checkOutput("coll_rvalid_clear", 32'(rvalid), 32'd0);
    checkOutput("coll_bvalid_clear", 32'(bvalid), 32'd0);
    axiRead(4'hC, 0);

    $display("[TB] randomized traffic");
    applyStimulus(40);
    axiRead(4'h4, 0);

    $display("[TB] reset mid-write");
    awvalid = 1; awaddr = 4'h8; awprot = 3'h0;
    waitEdge();
    awvalid = 0;
    checkOutput("mid_aw_full", 32'(awready), 32'd0);
    #2;
    rstN = 0;
    #1;
    for (int i = 0; i < 4; i++) model[i] = '0;
    checkRegOuts("in_reset");
    checkOutput("in_reset_rdata", rdata, 32'd0);
    checkOutput("in_reset_bvalid", 32'(bvalid), 32'd0);
    checkOutput("in_reset_rvalid", 32'(rvalid), 32'd0);
    checkOutput("in_reset_pulse", 32'(regWrPulse), 32'd0);
    checkOutput("in_reset_awready", 32'(awready), 32'd0);
    checkOutput("in_reset_wready", 32'(wready), 32'd0);
    checkOutput("in_reset_arready", 32'(arready), 32'd0);
    @(negedge clk);
    rstN = 1;
    waitEdge();
    checkOutput("rel_awready", 32'(awready), 32'd1);
    checkOutput("rel_wready", 32'(wready), 32'd1);
    checkOutput("rel_arready", 32'(arready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      waitEdge();
      checkOutput("rel_no_bvalid", 32'(bvalid), 32'd0);
    end
    for (int i = 0; i < 4; i++) axiRead(4'(4 * i), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
